// File: rtl/capture_ctrl_pkg.sv
// Shared types and helpers for the capture sequencer.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } cap_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Signal bundle between the capture sequencer and its neighbours
// (command processor, decimator, trigger logic, sample RAM).
interface capture_ctrl_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              run;
  logic              smpl_en;
  logic [ADDR_W-1:0] trig_pos;
  logic              triggered;
  logic              capture_done_clr;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic              armed;
  logic              set_capture_done;
  logic              capture_done;
  logic [ADDR_W-1:0] trig_addr;

  modport master (
    input  run, smpl_en, trig_pos, triggered, capture_done_clr,
    output we, waddr, armed, set_capture_done, capture_done, trig_addr
  );

  modport slave (
    output run, smpl_en, trig_pos, triggered, capture_done_clr,
    input  we, waddr, armed, set_capture_done, capture_done, trig_addr
  );
endinterface

// File: rtl/capture_ctrl_addr_cnt.sv
// Circular RAM write-address counter; wraps naturally at 2**ADDR_W.
module cap_addr_cnt #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,
  output logic [ADDR_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc) begin
      count <= count + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: pre-trigger fill, arm, post-trigger fill, done flag.
// Define CAPTURE_AUTO_REARM_EN to let a done-clear with run high re-enter PRE directly.
module capture_ctrl #(
  parameter int unsigned ADDR_W = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  capture_ctrl_if.master bus
);
  import capture_pkg::*;

  localparam int unsigned DEPTH = depth_of(ADDR_W);
  localparam int unsigned CNT_W = ADDR_W + 1;

  cap_state_t        state_q, state_d;
  logic [CNT_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]  post_cnt_q, post_cnt_d;
  logic              armed_q, armed_d;
  logic              done_q, done_d;
  logic              scd_q, scd_d;
  logic [ADDR_W-1:0] tp_q, tp_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CNT_W-1:0]  pre_sat;
  logic [CNT_W-1:0]  post_tgt;
  logic [ADDR_W-1:0] next_addr;

  assign we        = bus.smpl_en && (state_q == PRE || state_q == POST);
  assign pre_sat   = (pre_cnt_q == CNT_W'(DEPTH)) ? pre_cnt_q : pre_cnt_q + CNT_W'(we);
  assign post_tgt  = CNT_W'(DEPTH) - CNT_W'(tp_q);
  assign next_addr = waddr + ADDR_W'(we);

  cap_addr_cnt #(.ADDR_W(ADDR_W)) u_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (we),
    .count (waddr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      scd_q       <= 1'b0;
      tp_q        <= '0;
      trig_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      scd_q       <= scd_d;
      tp_q        <= tp_d;
      trig_addr_q <= trig_addr_d;
    end
  end

  // Next-state and registered-output logic; run low aborts PRE/POST.
  always_comb begin
    state_d     = state_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    armed_d     = armed_q;
    done_d      = done_q;
    scd_d       = 1'b0;
    tp_d        = tp_q;
    trig_addr_d = trig_addr_q;

    unique case (state_q)
      IDLE: begin
        pre_cnt_d = '0;
        armed_d   = 1'b0;
        if (bus.run && !done_q) begin
          state_d = PRE;
          tp_d    = bus.trig_pos;
        end
      end

      PRE: begin
        if (!bus.run) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else begin
          pre_cnt_d = pre_sat;
          if (bus.triggered && armed_q) begin
            state_d     = POST;
            trig_addr_d = next_addr;
            post_cnt_d  = '0;
          end else if (pre_sat >= CNT_W'(tp_q)) begin
            armed_d = 1'b1;
          end
        end
      end

      POST: begin
        if (!bus.run) begin
          state_d = IDLE;
          armed_d = 1'b0;
        end else if (we) begin
          if (post_cnt_q + CNT_W'(1) == post_tgt) begin
            state_d = DONE;
            scd_d   = 1'b1;
            done_d  = 1'b1;
            armed_d = 1'b0;
          end else begin
            post_cnt_d = post_cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        if (bus.capture_done_clr) begin
          done_d  = 1'b0;
`ifdef CAPTURE_AUTO_REARM_EN
          if (bus.run) begin
            state_d   = PRE;
            pre_cnt_d = '0;
            tp_d      = bus.trig_pos;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.we               = we;
  assign bus.waddr            = waddr;
  assign bus.armed            = armed_q;
  assign bus.set_capture_done = scd_q;
  assign bus.capture_done     = done_q;
  assign bus.trig_addr        = trig_addr_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Bench for capture_ctrl: directed scenarios plus random traffic against a
// sample-counting reference model.
module tb_capture_ctrl;

  localparam int unsigned AW = 4;
  localparam int          D  = 16;
`ifdef CAPTURE_AUTO_REARM_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  capture_ctrl_if #(.ADDR_W(AW)) bus ();
  capture_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  // stimulus for the current cycle
  bit i_rst_n = 1'b0, i_run = 1'b0, i_smpl = 1'b0, i_trig = 1'b0, i_clr = 1'b0;
  int i_tp = 0;

  // reference model: phase plus plain sample counts
  typedef enum {M_IDLE, M_PRE, M_POST, M_DONE} phase_t;
  phase_t ph = M_IDLE;
  int m_waddr = 0, m_pre_writes = 0, m_left = 0, m_tp = 0, m_taddr = 0;
  bit m_armed = 1'b0, m_done = 1'b0, m_scd = 1'b0;

  // per-scenario observations taken from the DUT
  int n_we = 0, n_scd = 0, arm_we = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input bit w);
    if (!i_rst_n) begin
      ph = M_IDLE; m_waddr = 0; m_pre_writes = 0; m_left = 0; m_tp = 0;
      m_taddr = 0; m_armed = 0; m_done = 0; m_scd = 0;
      return;
    end
    m_scd = 1'b0;
    case (ph)
      M_IDLE: begin
        m_pre_writes = 0;
        m_armed = 1'b0;
        if (i_run && !m_done) begin ph = M_PRE; m_tp = i_tp; end
      end
      M_PRE: begin
        if (!i_run) begin
          ph = M_IDLE; m_armed = 1'b0;
        end else begin
          m_pre_writes = (m_pre_writes + int'(w) > D) ? D : m_pre_writes + int'(w);
          if (i_trig && m_armed) begin
            ph = M_POST;
            m_taddr = (m_waddr + int'(w)) % D;
            m_left = D - m_tp;
          end else if (m_pre_writes >= m_tp) begin
            m_armed = 1'b1;
          end
        end
      end
      M_POST: begin
        if (!i_run) begin
          ph = M_IDLE; m_armed = 1'b0;
        end else if (w) begin
          m_left--;
          if (m_left == 0) begin
            ph = M_DONE; m_scd = 1'b1; m_done = 1'b1; m_armed = 1'b0;
          end
        end
      end
      M_DONE: begin
        if (i_clr) begin
          m_done = 1'b0;
          if (AUTO && i_run) begin
            ph = M_PRE; m_pre_writes = 0; m_tp = i_tp;
          end else begin
            ph = M_IDLE;
          end
        end
      end
      default: ph = M_IDLE;
    endcase
    m_waddr = (m_waddr + int'(w)) % D;
  endfunction

  // One clock: drive at negedge, compare every output against the model, advance model.
  task automatic cyc();
    bit exp_we;
    @(negedge clk);
    rst_n                = i_rst_n;
    bus.run              = i_run;
    bus.smpl_en          = i_smpl;
    bus.triggered        = i_trig;
    bus.capture_done_clr = i_clr;
    bus.trig_pos         = AW'(i_tp);
    #1;
    exp_we = i_smpl && (ph == M_PRE || ph == M_POST);
    check("we",               32'(bus.we),               32'(exp_we));
    check("waddr",            32'(bus.waddr),            32'(m_waddr));
    check("armed",            32'(bus.armed),            32'(m_armed));
    check("set_capture_done", 32'(bus.set_capture_done), 32'(m_scd));
    check("capture_done",     32'(bus.capture_done),     32'(m_done));
    check("trig_addr",        32'(bus.trig_addr),        32'(m_taddr));
    if (bus.armed === 1'b1 && arm_we < 0) arm_we = n_we;
    n_we  += int'(bus.we);
    n_scd += int'(bus.set_capture_done);
    model_step(exp_we);
  endtask

  task automatic start_scn();
    n_we = 0; n_scd = 0; arm_we = -1;
  endtask

  task automatic run_to_done(input int tp);
    i_tp = tp; i_run = 1'b1; i_trig = 1'b1; i_smpl = 1'b1;
    for (int k = 0; k < 60 && bus.capture_done !== 1'b1; k++) cyc();
  endtask

  task automatic clear_done();
    i_run = 1'b0; i_clr = 1'b1; i_smpl = 1'b0;
    cyc();
    i_clr = 1'b0;
    cyc();
  endtask

  initial begin
    bus.run = 1'b0; bus.smpl_en = 1'b0; bus.triggered = 1'b0;
    bus.capture_done_clr = 1'b0; bus.trig_pos = '0;

    // reset
    i_rst_n = 1'b0;
    repeat (2) cyc();
    i_rst_n = 1'b1;
    cyc();

    // trig_pos 4, triggered held from the start
    start_scn();
    run_to_done(4);
    check("A_done_reached", 32'(bus.capture_done), 32'd1);
    repeat (3) cyc();
    check("A_arm_after_writes", 32'(arm_we), 32'd4);
    check("A_total_writes", 32'(n_we), 32'd17);
    check("A_scd_pulses", 32'(n_scd), 32'd1);
    check("A_done_sticky", 32'(bus.capture_done), 32'd1);
    clear_done();
    check("A_done_cleared", 32'(bus.capture_done), 32'd0);

    // trig_pos 0
    start_scn();
    run_to_done(0);
    check("B_done_reached", 32'(bus.capture_done), 32'd1);
    check("B_arm_after_writes", 32'(arm_we), 32'd1);
    check("B_total_writes", 32'(n_we), 32'd18);
    check("B_scd_pulses", 32'(n_scd), 32'd1);
    clear_done();

    // park waddr at 14 via reset and an aborted pre-fill
    i_rst_n = 1'b0; cyc(); i_rst_n = 1'b1;
    i_tp = 15; i_run = 1'b1; i_trig = 1'b0; i_smpl = 1'b0;
    cyc();
    i_smpl = 1'b1;
    repeat (14) cyc();
    i_run = 1'b0; i_smpl = 1'b0;
    cyc();
    cyc();
    check("C_waddr_start", 32'(bus.waddr), 32'd14);
    check("C_not_armed", 32'(bus.armed), 32'd0);

    // trig_pos 15 across the wrap
    start_scn();
    run_to_done(15);
    check("C_done_reached", 32'(bus.capture_done), 32'd1);
    check("C_arm_after_writes", 32'(arm_we), 32'd15);
    check("C_total_writes", 32'(n_we), 32'd17);
    check("C_trig_addr", 32'(bus.trig_addr), 32'd14);
    check("C_waddr_end", 32'(bus.waddr), 32'd15);
    clear_done();

    // sparse strobes, then run dropped mid-POST
    start_scn();
    i_tp = 4; i_run = 1'b1; i_trig = 1'b1;
    for (int k = 0; k < 30; k++) begin
      i_smpl = (k % 3 == 0);
      cyc();
    end
    check("D_in_post_armed", 32'(bus.armed), 32'd1);
    check("D_writes", 32'(n_we), 32'd9);
    i_run = 1'b0; i_smpl = 1'b0;
    repeat (3) cyc();
    check("D_abort_no_scd", 32'(n_scd), 32'd0);
    check("D_abort_done", 32'(bus.capture_done), 32'd0);
    check("D_abort_armed", 32'(bus.armed), 32'd0);

    // done-clear together with run
    start_scn();
    run_to_done(4);
    check("E_done_reached", 32'(bus.capture_done), 32'd1);
    i_clr = 1'b1; i_run = 1'b1; i_smpl = 1'b1;
    cyc();
    i_clr = 1'b0;
    cyc();
    check("E_we_after_clr", 32'(bus.we), 32'(AUTO));
    cyc();
    check("E_we_second", 32'(bus.we), 32'd1);

    // reset in the middle of POST
    i_tp = 2; i_trig = 1'b1; i_run = 1'b1; i_smpl = 1'b1;
    repeat (12) cyc();
    i_rst_n = 1'b0; cyc(); i_rst_n = 1'b1;
    cyc();
    check("F_we", 32'(bus.we), 32'd0);
    check("F_waddr", 32'(bus.waddr), 32'd0);
    check("F_armed", 32'(bus.armed), 32'd0);
    check("F_trig_addr", 32'(bus.trig_addr), 32'd0);
    check("F_done", 32'(bus.capture_done), 32'd0);
    check("F_scd", 32'(bus.set_capture_done), 32'd0);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      i_rst_n = ($urandom_range(0, 499) != 0);
      i_run   = ($urandom_range(0, 19) != 0);
      i_smpl  = ($urandom_range(0, 1) == 1);
      i_trig  = ($urandom_range(0, 3) == 0);
      i_clr   = ($urandom_range(0, 9) == 0);
      i_tp    = int'($urandom_range(0, D - 1));
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/capture_ctrl.md
Name: capture_ctrl

Overview:
Capture sequencer that drives the trigger logic's `armed` and `set_capture_done` inputs and consumes its `triggered` output. It also generates write address and write-enable for the circular sample RAM.
- Pre-trigger phase: fills the RAM with `trig_pos` samples before arming.
- Post-trigger phase: after `triggered`, writes the remaining `DEPTH - trig_pos` samples, then flags the capture as done.
- Sits between the command processor, the decimator strobe, trigger_logic and the sample RAMs.

Parameters:
- ADDR_W, 9, sample RAM address width; DEPTH = 2**ADDR_W samples.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset, sampled on posedge clk
- run  input  1  level; capture enabled while high
- smpl_en  input  1  one-cycle sample strobe from decimator
- trig_pos  input  ADDR_W  pre-trigger sample count, 0..DEPTH-1
- triggered  input  1  from trigger_logic
- capture_done_clr  input  1  one-cycle clear from command processor
- we  output  1  RAM write enable
- waddr  output  ADDR_W  RAM write address
- armed  output  1  to trigger_logic
- set_capture_done  output  1  one-cycle pulse to trigger_logic
- capture_done  output  1  sticky done flag
- trig_addr  output  ADDR_W  waddr of first post-trigger write

Behaviour:
- Reset values: all state and outputs are 0; state = IDLE.
- `we = smpl_en` in PRE and POST, 0 elsewhere (combinational).
- `waddr` advances by 1 on every write and wraps DEPTH-1 -> 0. It is not cleared on run start, only on reset.
- IDLE:
  - `run && !capture_done` -> PRE.
  - Clear `pre_cnt` (ADDR_W+1 bits) and `armed`.
- PRE:
  - Each write increments `pre_cnt`, saturating at DEPTH.
  - `armed` is registered: it is set on the clock edge where `pre_cnt >= trig_pos` (counting the write occurring that cycle), so it is visible the next cycle. With `trig_pos = 0`, `armed` is high the first cycle after entering PRE.
  - `triggered && armed` -> POST. On that edge, `trig_addr` latches the address of the next write (`waddr` plus 1 if this cycle wrote, else `waddr`). Clear `post_cnt` (ADDR_W+1 bits).
  - `triggered` while `armed = 0` is ignored.
- POST:
  - `armed` stays 1. Each write increments `post_cnt`.
  - On the write where `post_cnt + 1 == DEPTH - trig_pos`: set `set_capture_done` = 1 for exactly the next cycle, set `capture_done` = 1, clear `armed`, -> DONE.
  - `trig_pos` is sampled into a register on IDLE->PRE; later changes are ignored until the next capture.
- DONE:
  - No writes; `capture_done` holds.
  - `capture_done_clr` -> clear `capture_done`, -> IDLE.
- Abort: `run` low in PRE or POST -> IDLE next cycle. `armed` is cleared, no `set_capture_done`, `capture_done` is unchanged.
- Precedence:
  - `rst_n` low beats everything.
  - `capture_done_clr` beats `run` in the same cycle.
  - In PRE, a write and the transition to POST may occur in the same cycle; that write counts as pre-trigger.

Optional Feature:
- CAPTURE_AUTO_REARM_EN
  - Defined: in DONE, `capture_done_clr` with `run` high goes directly to PRE. `pre_cnt` is cleared and `trig_pos` is resampled that cycle.
  - Undefined: `capture_done_clr` always goes to IDLE; re-entry to PRE takes one extra cycle.

Decomposition:
- Package `capture_pkg`: state enum `cap_state_t` {IDLE, PRE, POST, DONE} (2-bit), and a function for DEPTH from ADDR_W.
- Sub-module `cap_addr_cnt`: ADDR_W wrap counter with increment enable and synchronous active-low reset; produces `waddr`.

Test Plan (ADDR_W=4, DEPTH=16, `smpl_en` every cycle unless stated):
- Reset mid-POST: `rst_n` low one cycle -> next cycle all outputs 0, state IDLE, `waddr` 0.
- `trig_pos` 4, `run` 1:
  - `armed` rises the cycle after the 4th write.
  - `triggered` held 1 from start is ignored until `armed`.
  - Exactly 12 POST writes, then `set_capture_done` high for 1 cycle and `capture_done` stays 1.
- `trig_pos` 0: `armed` 1 cycle after PRE entry; 16 post writes; `trig_addr` equals the first POST `waddr`.
- `trig_pos` 15 with `waddr` starting at 14: wrap 15->0 is correct, and exactly 1 post write occurs before done.
- `smpl_en` every 3rd cycle: `we` only on strobes; `pre_cnt`/`post_cnt` counts match; `run` dropped mid-POST -> IDLE with no `set_capture_done`.
- `capture_done_clr` and `run` both 1 in DONE:
  - Macro off: IDLE, then PRE the following cycle.
  - Macro on: directly PRE.
